// File: rtl/booth_pkg.sv
// Shared Booth radix-4 encoding and Wallace tree shape helpers for booth_wallace_pipe.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_dig_e;

  function automatic booth_dig_e booth_sel(input logic [2:0] win);
    booth_dig_e d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  function automatic int npp(input int width);
    return (width + 3) / 2;
  endfunction

  // Rows left after one level of 3:2 compression.
  function automatic int csa_next(input int rows);
    return 2 * (rows / 3) + rows % 3;
  endfunction

  function automatic int tree_levels(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = csa_next(n);
      l++;
    end
    return l;
  endfunction

  function automatic int level_rows(input int rows, input int lvl);
    int n;
    n = rows;
    for (int i = 0; i < lvl; i++) n = csa_next(n);
    return n;
  endfunction

  function automatic int level_base(input int rows, input int lvl);
    int n;
    int b;
    n = rows;
    b = 0;
    for (int i = 0; i < lvl; i++) begin
      b += n;
      n = csa_next(n);
    end
    return b;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product rows, aligned and truncated to 2*WIDTH bits.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NPP   = npp(WIDTH)
) (
  input  logic [WIDTH-1:0]              a_i,
  input  logic [WIDTH-1:0]              b_i,
  input  logic                          signed_i,
  output logic [NPP-1:0][2*WIDTH-1:0]   rows_o
);

  localparam int P  = 2 * WIDTH;
  localparam int L  = WIDTH + 3;
  localparam int BW = 2 * NPP + 1;

  logic [L-1:0]  a_ext;
  logic [L-1:0]  mag;
  logic [L-1:0]  pp;
  logic [BW-1:0] b_ext;
  logic          neg;
  logic          neg_prev;
  logic          s;
  int            pos;
  booth_dig_e    dig;

  always_comb begin
    a_ext    = {{3{signed_i & a_i[WIDTH-1]}}, a_i};
    b_ext    = {{(BW-WIDTH-1){signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};
    rows_o   = '0;
    mag      = '0;
    pp       = '0;
    neg      = 1'b0;
    neg_prev = 1'b0;
    s        = 1'b0;
    pos      = 0;
    dig      = ZERO;
    for (int j = 0; j < NPP; j++) begin
      dig = booth_sel(b_ext[2*j +: 3]);
      case (dig)
        P1, M1:  mag = a_ext;
        P2, M2:  mag = {a_ext[L-2:0], 1'b0};
        default: mag = '0;
      endcase
      neg = (dig == M1) || (dig == M2);
      pp  = neg ? ~mag : mag;
      s   = pp[L-1];
      for (int k = 0; k < L; k++) begin
        pos = 2 * j + k;
        if (pos < P) rows_o[j][pos] = pp[k];
      end
      // Constant-ones prefixes: their combined weight lands at or above 2^P and vanishes.
      if (j == 0) begin
        pos = L;
        if (pos < P) rows_o[j][pos] = s;
        pos = L + 1;
        if (pos < P) rows_o[j][pos] = s;
        pos = L + 2;
        if (pos < P) rows_o[j][pos] = ~s;
      end else begin
        pos = 2 * j + L;
        if (pos < P) rows_o[j][pos] = ~s;
        pos = 2 * j + L + 1;
        if (pos < P) rows_o[j][pos] = 1'b1;
        rows_o[j][2*j-2] = neg_prev;
      end
      // The top digit is never negative, so its +1 never needs a home.
      neg_prev = neg;
    end
  end

endmodule

// File: rtl/nbit_csa.sv
// N-bit 3:2 carry-save adder; carry output is pre-shifted and truncated to N bits.
module nbit_csa #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = {(a_i[N-2:0] & b_i[N-2:0]) | (a_i[N-2:0] & c_i[N-2:0]) |
                (b_i[N-2:0] & c_i[N-2:0]), 1'b0};

endmodule

// File: rtl/booth_wallace_pipe.sv
// Three-stage elastic Booth/Wallace multiplier: S1 encode, S2 CSA tree, S3 optional CPA.
module booth_wallace_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ai,
  input  logic [WIDTH-1:0]   bi,
  input  logic               signed_mode,
  input  logic               cpa_en,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] so,
  output logic [2*WIDTH-1:0] co,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P      = 2 * WIDTH;
  localparam int NPP    = npp(WIDTH);
  localparam int LEVELS = tree_levels(NPP);
  localparam int NODES  = level_base(NPP, LEVELS) + 2;

  logic                    adv1, adv2, adv3;
  logic [NPP-1:0][P-1:0]   rows_d;
  logic [NPP-1:0][P-1:0]   rows_p1_q;
  logic                    vld_p1_q, cpa_p1_q;
  logic [TAG_W-1:0]        tag_p1_q;
  logic [NODES-1:0][P-1:0] node;
  logic                    vld_p2_q, cpa_p2_q;
  logic [TAG_W-1:0]        tag_p2_q;
  logic [P-1:0]            sum_p2_q, car_p2_q;
  logic [P-1:0]            so_d, co_d;
  logic                    vld_p3_q;
  logic [P-1:0]            so_q, co_q;
  logic [TAG_W-1:0]        tag_p3_q;

  assign adv3     = !vld_p3_q || out_ready;
  assign adv2     = !vld_p2_q || adv3;
  assign adv1     = !vld_p1_q || adv2;
  assign in_ready = adv1 && !rst;

  booth_pp_gen #(.WIDTH(WIDTH), .NPP(NPP)) u_pp_gen (
    .a_i      (ai),
    .b_i      (bi),
    .signed_i (signed_mode),
    .rows_o   (rows_d)
  );

  // ---- S1: Booth rows ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else if (adv1) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1) begin
      rows_p1_q <= rows_d;
      cpa_p1_q  <= cpa_en;
      tag_p1_q  <= in_tag;
    end
  end

  for (genvar i = 0; i < NPP; i++) begin : g_leaf
    assign node[i] = rows_p1_q[i];
  end

  // Each level's outputs are appended after its inputs; the last two nodes are the result.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int RIN  = level_rows(NPP, l);
    localparam int BIN  = level_base(NPP, l);
    localparam int BOUT = level_base(NPP, l + 1);
    localparam int NCSA = RIN / 3;
    for (genvar k = 0; k < NCSA; k++) begin : g_csa
      nbit_csa #(.N(P)) u_csa (
        .a_i (node[BIN+3*k]),
        .b_i (node[BIN+3*k+1]),
        .c_i (node[BIN+3*k+2]),
        .s_o (node[BOUT+2*k]),
        .c_o (node[BOUT+2*k+1])
      );
    end
    for (genvar k = 0; k < RIN % 3; k++) begin : g_pass
      assign node[BOUT+2*NCSA+k] = node[BIN+3*NCSA+k];
    end
  end

  // ---- S2: carry-save pair ----
  always_ff @(posedge clk) begin
    if (rst) vld_p2_q <= 1'b0;
    else if (adv2) vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (adv2) begin
      sum_p2_q <= node[NODES-2];
      car_p2_q <= node[NODES-1];
      cpa_p2_q <= cpa_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  always_comb begin
    so_d = sum_p2_q;
    co_d = car_p2_q;
    if (cpa_p2_q) begin
      so_d = sum_p2_q + car_p2_q;
      co_d = '0;
    end
  end

  // ---- S3: output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3_q <= 1'b0;
      so_q     <= '0;
      co_q     <= '0;
      tag_p3_q <= '0;
    end else if (adv3) begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        so_q     <= so_d;
        co_q     <= co_d;
        tag_p3_q <= tag_p2_q;
      end
    end
  end

  assign out_valid = vld_p3_q;
  assign so        = so_q;
  assign co        = co_q;
  assign out_tag   = tag_p3_q;

endmodule

// File: tb/tb_booth_wallace_pipe.sv
// Randomized and directed bench for booth_wallace_pipe at WIDTH=11 and WIDTH=24.
module tb_booth_wallace_pipe;

  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          v11, r11, sm11, cpa11, ov11, or11;
  logic [10:0]   a11, b11;
  logic [TW-1:0] tg11, ot11;
  logic [21:0]   so11, co11;

  logic          v24, r24, sm24, cpa24, ov24, or24;
  logic [23:0]   a24, b24;
  logic [TW-1:0] tg24, ot24;
  logic [47:0]   so24, co24;

  booth_wallace_pipe #(.WIDTH(11), .TAG_W(TW)) u_dut11 (
    .clk(clk), .rst(rst), .in_valid(v11), .in_ready(r11), .ai(a11), .bi(b11),
    .signed_mode(sm11), .cpa_en(cpa11), .in_tag(tg11), .out_valid(ov11),
    .out_ready(or11), .so(so11), .co(co11), .out_tag(ot11)
  );

  booth_wallace_pipe #(.WIDTH(24), .TAG_W(TW)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(v24), .in_ready(r24), .ai(a24), .bi(b24),
    .signed_mode(sm24), .cpa_en(cpa24), .in_tag(tg24), .out_valid(ov24),
    .out_ready(or24), .so(so24), .co(co24), .out_tag(ot24)
  );

  int checks   = 0;
  int failures = 0;
  int nout11   = 0;
  int nout24   = 0;

  typedef struct {
    logic [63:0]   prod;
    logic          cpa;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q11[$];
  exp_t q24[$];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Exact integer product in the chosen mode, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm, input int w);
    longint sa, sb, p;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  logic          st11;
  logic [21:0]   hso11, hco11, sum11;
  logic [TW-1:0] hot11;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q11.delete();
      st11 = 1'b0;
    end else begin
      if (st11) begin
        chk_eq("w11_hold_valid", 64'(ov11), 64'd1);
        chk_eq("w11_hold_so", 64'(so11), 64'(hso11));
        chk_eq("w11_hold_co", 64'(co11), 64'(hco11));
        chk_eq("w11_hold_tag", 64'(ot11), 64'(hot11));
      end
      if (ov11 && or11) begin
        chk_eq("w11_out_expected", 64'(q11.size() > 0), 64'd1);
        if (q11.size() > 0) begin
          e = q11.pop_front();
          sum11 = so11 + co11;
          chk_eq("w11_product", 64'(sum11), e.prod);
          if (e.cpa) chk_eq("w11_co_zero", 64'(co11), 64'd0);
          chk_eq("w11_tag", 64'(ot11), 64'(e.tag));
          nout11++;
        end
      end
      st11  = ov11 && !or11;
      hso11 = so11;
      hco11 = co11;
      hot11 = ot11;
      if (v11 && r11) q11.push_back('{ref_mul(32'(a11), 32'(b11), sm11, 11), cpa11, tg11});
    end
  end

  logic          st24;
  logic [47:0]   hso24, hco24, sum24;
  logic [TW-1:0] hot24;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q24.delete();
      st24 = 1'b0;
    end else begin
      if (st24) begin
        chk_eq("w24_hold_so", 64'(so24), 64'(hso24));
        chk_eq("w24_hold_co", 64'(co24), 64'(hco24));
        chk_eq("w24_hold_tag", 64'(ot24), 64'(hot24));
      end
      if (ov24 && or24) begin
        chk_eq("w24_out_expected", 64'(q24.size() > 0), 64'd1);
        if (q24.size() > 0) begin
          e = q24.pop_front();
          sum24 = so24 + co24;
          chk_eq("w24_product", 64'(sum24), e.prod);
          if (e.cpa) chk_eq("w24_co_zero", 64'(co24), 64'd0);
          chk_eq("w24_tag", 64'(ot24), 64'(e.tag));
          nout24++;
        end
      end
      st24  = ov24 && !or24;
      hso24 = so24;
      hco24 = co24;
      hot24 = ot24;
      if (v24 && r24) q24.push_back('{ref_mul(32'(a24), 32'(b24), sm24, 24), cpa24, tg24});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op11(input logic [10:0] a, input logic [10:0] b, input logic sm,
                      input logic cpa, input logic [TW-1:0] tg);
    a11 = a; b11 = b; sm11 = sm; cpa11 = cpa; tg11 = tg; v11 = 1'b1;
    tick();
    v11 = 1'b0;
    chk_eq("lat_cycle1", 64'(ov11), 64'd0);
    tick();
    chk_eq("lat_cycle2", 64'(ov11), 64'd0);
    tick();
    chk_eq("lat_cycle3", 64'(ov11), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n0;
    logic [21:0] s;
    rst = 1'b1;
    v11 = 0; a11 = '0; b11 = '0; sm11 = 0; cpa11 = 0; tg11 = '0; or11 = 1'b1;
    v24 = 0; a24 = '0; b24 = '0; sm24 = 0; cpa24 = 0; tg24 = '0; or24 = 1'b1;
    repeat (3) tick();
    chk_eq("rst_in_ready_low", 64'(r11), 64'd0);
    rst = 1'b0;
    #1;
    chk_eq("rst_in_ready", 64'(r11), 64'd1);
    chk_eq("rst_out_valid", 64'(ov11), 64'd0);
    chk_eq("rst_so", 64'(so11), 64'd0);
    chk_eq("rst_co", 64'(co11), 64'd0);
    chk_eq("rst_tag", 64'(ot11), 64'd0);

    // Unsigned all-ones with CPA.
    op11(11'h7FF, 11'h7FF, 1'b0, 1'b1, 4'd3);
    chk_eq("u_ones_so", 64'(so11), 64'h3FF001);
    chk_eq("u_ones_co", 64'(co11), 64'd0);
    chk_eq("u_ones_tag", 64'(ot11), 64'd3);

    // Signed, carry-save output.
    op11(11'h400, 11'h7FF, 1'b1, 1'b0, 4'd5);
    s = so11 + co11;
    chk_eq("s_min_x_m1", 64'(s), 64'h000400);
    op11(11'h400, 11'h400, 1'b1, 1'b0, 4'd6);
    s = so11 + co11;
    chk_eq("s_min_x_min", 64'(s), 64'h100000);

    // Eight back-to-back operations, mixed modes.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        a11 = 11'($urandom); b11 = 11'($urandom);
        sm11 = c[0]; cpa11 = c[1]; tg11 = TW'(c); v11 = 1'b1;
      end else begin
        v11 = 1'b0;
      end
      tick();
      if (c >= 2) begin
        chk_eq("b2b_valid", 64'(ov11), 64'd1);
        chk_eq("b2b_order", 64'(ot11), 64'(c - 2));
      end
    end
    v11 = 1'b0;
    tick();

    // Stall with a full pipe.
    or11 = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      a11 = 11'($urandom); b11 = 11'($urandom); sm11 = 1'($urandom);
      cpa11 = 1'($urandom); tg11 = TW'(c + 8); v11 = 1'b1;
      if (r11) acc++;
      tick();
    end
    v11 = 1'b0;
    chk_eq("stall_accepts", 64'(acc), 64'd3);
    chk_eq("stall_in_ready", 64'(r11), 64'd0);
    chk_eq("stall_out_valid", 64'(ov11), 64'd1);
    n0 = nout11;
    or11 = 1'b1;
    repeat (6) tick();
    chk_eq("stall_delivered", 64'(nout11 - n0), 64'd3);
    chk_eq("stall_queue_empty", 64'(q11.size()), 64'd0);

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      a11 = 11'($urandom); b11 = 11'($urandom); sm11 = 0; cpa11 = 1;
      tg11 = TW'(c); v11 = 1'b1;
      tick();
    end
    v11 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("midrst_out_valid", 64'(ov11), 64'd0);
    chk_eq("midrst_so", 64'(so11), 64'd0);
    chk_eq("midrst_co", 64'(co11), 64'd0);
    n0 = nout11;
    repeat (5) tick();
    chk_eq("midrst_no_stale", 64'(nout11 - n0), 64'd0);
    op11(11'h123, 11'h456, 1'b0, 1'b1, 4'd9);
    chk_eq("postrst_so", 64'(so11), 64'h04EDC2);
    chk_eq("postrst_tag", 64'(ot11), 64'd9);
    tick();

    // Random traffic, WIDTH=11.
    for (int i = 0; i < 3000; i++) begin
      v11 = ($urandom % 4) != 0;
      a11 = 11'($urandom); b11 = 11'($urandom);
      if (($urandom % 8) == 0) a11 = (($urandom % 2) == 0) ? 11'h7FF : 11'h400;
      if (($urandom % 8) == 0) b11 = (($urandom % 2) == 0) ? 11'h7FF : 11'h000;
      sm11 = 1'($urandom); cpa11 = 1'($urandom); tg11 = TW'($urandom);
      or11 = ($urandom % 3) != 0;
      tick();
    end
    v11 = 1'b0;
    or11 = 1'b1;
    repeat (8) tick();
    chk_eq("w11_drain", 64'(q11.size()), 64'd0);

    // WIDTH=24 boundaries.
    a24 = 24'hFFFFFF; b24 = 24'hFFFFFF; sm24 = 0; cpa24 = 1; tg24 = 4'd2; v24 = 1'b1;
    tick();
    v24 = 1'b0;
    repeat (2) tick();
    chk_eq("w24_ones_valid", 64'(ov24), 64'd1);
    chk_eq("w24_ones_so", 64'(so24), 64'hFFFFFE000001);
    chk_eq("w24_ones_co", 64'(co24), 64'd0);
    a24 = 24'h800000; b24 = 24'h800000; sm24 = 1; cpa24 = 1; tg24 = 4'd7; v24 = 1'b1;
    tick();
    v24 = 1'b0;
    repeat (2) tick();
    chk_eq("w24_min_so", 64'(so24), 64'h400000000000);
    tick();

    // Random traffic, WIDTH=24.
    for (int i = 0; i < 2000; i++) begin
      v24 = ($urandom % 4) != 0;
      a24 = 24'($urandom); b24 = 24'($urandom);
      sm24 = 1'($urandom); cpa24 = 1'($urandom); tg24 = TW'($urandom);
      or24 = ($urandom % 3) != 0;
      tick();
    end
    v24 = 1'b0;
    or24 = 1'b1;
    repeat (8) tick();
    chk_eq("w24_drain", 64'(q24.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
